uart_tx_stream: RTL
===================

Name: uart_tx_stream

Overview:
- Byte-stream UART transmitter, 8N1 (8 data bits, no parity, 1 stop bit), LSB first, with a small input FIFO.
- It is the sending end of the serial link whose receiving end is the uart_rx input of stochastic_repl_core.
- Used as the host-side command driver in simulation benches and as the core's outbound response serializer.
- Accepts bytes over a valid/ready handshake and emits back-to-back frames with no idle gap while data is queued.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be at least 2.
- FIFO_DEPTH, 4, input FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- tx_data  input  8  byte to send.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  FIFO can accept a byte; combinational !full, derived from registered count.
- tx  output  1  serial line, registered; idles high.
- busy  output  1  high while a frame is on the line or FIFO is non-empty.
- tx_done  output  1  one-cycle pulse on the final cycle of each stop bit.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued bytes, excluding the byte in flight.

Behaviour:
- Clock and reset: single clock domain, single clock. Reset is synchronous and active-high; rst is sampled only on the rising edge of clk.
- Reset values: tx=1, tx_ready=1, busy=0, tx_done=0, fifo_count=0. FSM=IDLE, bit counter=0, baud counter=0, FIFO pointers=0.
- Reset mid-frame: on the edge where rst is high, tx returns to 1 and the FIFO is flushed. No tx_done is generated. The truncated frame is not resumed.
- Handshake:
  - A byte is written on any edge where tx_valid && tx_ready.
  - The producer must hold tx_data stable while tx_valid is high and tx_ready is low.
  - When full, a push is refused even if a pop occurs on the same edge (no bypass).
  - When not full, simultaneous push and pop are both performed and fifo_count is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register, drive tx=0 on the same edge, and go to START.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then drive shift[0] and go to DATA with bit_idx=0.
  - DATA: each bit is held for CLKS_PER_BIT cycles, LSB first. After bit 7, drive tx=1 and go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. tx_done=1 on the last of these cycles. On the following edge:
    - if the FIFO is non-empty, pop and drive tx=0 (back-to-back, no idle cycle);
    - otherwise go to IDLE.
- Latency and timing:
  - A handshake into an empty FIFO with the FSM in IDLE at edge E0 causes tx to fall at edge E0+1.
  - A frame is exactly 10*CLKS_PER_BIT cycles from tx falling edge to the next start-bit opportunity.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary; it is reset to 0 on every frame start.
- FIFO pointers: $clog2(FIFO_DEPTH) bits wide, wrapping naturally. fifo_count saturates structurally at FIFO_DEPTH.
- busy = (state != IDLE) || (fifo_count != 0).

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- Reset: hold rst for 3 cycles with tx_valid=1 -> tx=1, tx_ready=1, busy=0, fifo_count=0 throughout, and no byte accepted.
- Single byte: push 0xA5 -> tx falls 1 cycle after the handshake. Sampling mid-bit gives 0,1,0,1,0,0,1,0,1,1. tx_done pulses exactly once, 40 cycles after tx falls. busy drops on the next cycle.
- Back-pressure: push 0x01..0x06 with tx_valid held high ->
  - tx_ready falls when fifo_count=4;
  - each blocked byte enters on the cycle a pop frees a slot;
  - six contiguous 40-cycle frames go out in order with no idle cycle between them;
  - exactly six tx_done pulses occur.
- Simultaneous push/pop: push a byte on the edge the FSM pops from a 1-entry FIFO -> fifo_count stays 1 and both bytes are sent in order.
- Reset mid-frame: assert rst for 1 cycle during data bit 3 of 0x3C with 2 bytes queued -> tx=1 on the next edge, fifo_count=0, no tx_done, and the queued bytes are never sent.
- Throughput at default CLKS_PER_BIT=868: 16 random bytes, decoded by a bench 8N1 reference receiver -> all bytes match in order, and each frame is 8680 cycles.

Source files
------------

// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - 8N1 byte-stream UART transmitter with a small input FIFO
//
// Bytes are accepted over a valid/ready handshake into a FIFO and then sent
// LSB first as 8N1 frames. While data is queued, frames go out back to back
// with no idle gap between them.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   tx_data    byte to send
//   tx_valid   tx_data is valid
//   tx_ready   FIFO can accept a byte (combinational !full from the registered count)
//   tx         registered serial line, idles high
//   busy       a frame is on the line or the FIFO is non-empty
//   tx_done    one-cycle pulse on the final cycle of each stop bit
//   fifo_count queued bytes, not counting the byte in flight
module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO storage and pointers; pointers wrap naturally at FIFO_DEPTH.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          empty;

    // Transmit FSM and datapath.
    state_t        state, state_nx;
    logic [BW-1:0] baud, baud_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shift, shift_nx;
    logic          tx_nx;
    logic          bit_end;

    assign empty      = (count == '0);
    assign tx_ready   = (count != FULL);
    assign push       = tx_valid && tx_ready;
    assign fifo_count = count;
    assign busy       = (state != IDLE) || !empty;
    assign bit_end    = (baud == BAUD_LAST);
    assign tx_done    = (state == STOP) && bit_end;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Pushes are gated by tx_ready, which is derived from the registered
    // count, so a full FIFO refuses a push even when a pop frees a slot on
    // the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nx;
            baud    <= baud_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
            tx      <= tx_nx;
        end
    end

    // tx is registered, so every transition drives the value the line takes
    // for the coming bit period. shift is consumed right to left; shift[1]
    // is the next data bit to present.
    always_comb begin
        state_nx   = state;
        baud_nx    = bit_end ? '0 : baud + BW'(1);
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        tx_nx      = tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                baud_nx = '0;
                tx_nx   = 1'b1;
                if (!empty) begin
                    pop      = 1'b1;
                    shift_nx = mem[rd_ptr];
                    tx_nx    = 1'b0;
                    state_nx = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_nx      = shift[0];
                    bit_idx_nx = '0;
                    state_nx   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        tx_nx    = 1'b1;
                        state_nx = STOP;
                    end else begin
                        tx_nx      = shift[1];
                        shift_nx   = shift >> 1;
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        shift_nx = mem[rd_ptr];
                        tx_nx    = 1'b0;
                        state_nx = START;
                    end else begin
                        tx_nx    = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                tx_nx    = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

endmodule
